// File: rtl/load_store_unit.sv
// Load/store unit: turns an ALU effective address into a single request/ack data-memory
// transaction, with byte-lane steering, load extension and error reporting.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lsu_req,
    input  logic        lsu_we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        lsu_busy,
    output logic        lsu_done,
    output logic [1:0]  lsu_err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int CW = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 32'd1);

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_ALIGN = 2'b01;
    localparam logic [1:0] ERR_F3    = 2'b10;
    localparam logic [1:0] ERR_TMO   = 2'b11;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        logic bad;
        if (we) begin
            bad = (f3 >= 3'b011);
        end else begin
            case (f3)
                3'b011, 3'b110, 3'b111: bad = 1'b1;
                default:                bad = 1'b0;
            endcase
        end
        return bad;
    endfunction

    // Size is encoded in funct3[1:0] once funct3 is known to be legal.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3[1:0])
            2'b01:   bad = off[0];
            2'b10:   bad = (off != 2'b00);
            default: bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] d);
        logic [31:0] r;
        case (f3[1:0])
            2'b00:   r = {4{d[7:0]}};
            2'b01:   r = {2{d[15:0]}};
            2'b10:   r = d;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] lane);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{lane[7]}}, lane[7:0]};
            3'b001:  r = {{16{lane[15]}}, lane[15:0]};
            3'b010:  r = lane;
            3'b100:  r = {24'd0, lane[7:0]};
            3'b101:  r = {16'd0, lane[15:0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    state_t        state_r, state_s;
    logic [CW-1:0] cnt_r, cnt_s;
    logic [2:0]    funct3_r, funct3_s;
    logic [1:0]    off_r, off_s;
    logic          we_r, we_s;

    logic          busy_s, done_s, req_s, mwe_s;
    logic [1:0]    err_s;
    logic [31:0]   rdata_s, maddr_s, mwdata_s, lane_s;
    logic [3:0]    mbe_s;

    assign lane_s = mem_rdata >> {off_r, 3'b000};

    // Next-state and next-output logic; every register holds unless overridden.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        funct3_s = funct3_r;
        off_s    = off_r;
        we_s     = we_r;
        busy_s   = lsu_busy;
        done_s   = 1'b0;
        err_s    = lsu_err;
        rdata_s  = rdata;
        req_s    = mem_req;
        mwe_s    = mem_we;
        maddr_s  = mem_addr;
        mbe_s    = mem_be;
        mwdata_s = mem_wdata;

        case (state_r)
            IDLE: begin
                if (lsu_req) begin
                    if (f3_illegal(lsu_we, funct3)) begin
                        done_s  = 1'b1;
                        err_s   = ERR_F3;
                        rdata_s = 32'd0;
                    end else if (misaligned(funct3, addr[1:0])) begin
                        done_s  = 1'b1;
                        err_s   = ERR_ALIGN;
                        rdata_s = 32'd0;
                    end else begin
                        state_s  = ACCESS;
                        cnt_s    = '0;
                        funct3_s = funct3;
                        off_s    = addr[1:0];
                        we_s     = lsu_we;
                        busy_s   = 1'b1;
                        req_s    = 1'b1;
                        mwe_s    = lsu_we;
                        maddr_s  = {addr[31:2], 2'b00};
                        mbe_s    = byte_en(funct3, addr[1:0]);
                        mwdata_s = lsu_we ? store_data(funct3, wdata) : 32'd0;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            ACCESS: begin
                // An ack in the last counted cycle takes priority over the timeout.
                if (mem_ack || ((TIMEOUT > 32'd0) && (cnt_r == CNT_LAST))) begin
                    state_s  = IDLE;
                    busy_s   = 1'b0;
                    done_s   = 1'b1;
                    req_s    = 1'b0;
                    mwe_s    = 1'b0;
                    maddr_s  = 32'd0;
                    mbe_s    = 4'b0000;
                    mwdata_s = 32'd0;
                    if (mem_ack) begin
                        err_s   = ERR_OK;
                        rdata_s = we_r ? 32'd0 : load_ext(funct3_r, lane_s);
                    end else begin
                        err_s   = ERR_TMO;
                        rdata_s = 32'd0;
                    end
                end else begin
                    cnt_s = cnt_r + CW'(32'd1);
                end
            end
            default: begin
                state_s = IDLE;
                busy_s  = 1'b0;
                req_s   = 1'b0;
            end
        endcase
    end

    // State and registered-output update with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            funct3_r  <= 3'b000;
            off_r     <= 2'b00;
            we_r      <= 1'b0;
            lsu_busy  <= 1'b0;
            lsu_done  <= 1'b0;
            lsu_err   <= 2'b00;
            rdata     <= 32'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_be    <= 4'b0000;
            mem_wdata <= 32'd0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            funct3_r  <= funct3_s;
            off_r     <= off_s;
            we_r      <= we_s;
            lsu_busy  <= busy_s;
            lsu_done  <= done_s;
            lsu_err   <= err_s;
            rdata     <= rdata_s;
            mem_req   <= req_s;
            mem_we    <= mwe_s;
            mem_addr  <= maddr_s;
            mem_be    <= mbe_s;
            mem_wdata <= mwdata_s;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: the driver queues expected completions, a
// negedge monitor pops and compares them whenever lsu_done is seen.
module tb_load_store_unit;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        lsu_req = 1'b0;
    logic        lsu_we = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        lsu_busy, lsu_done;
    logic [1:0]  lsu_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .lsu_req(lsu_req), .lsu_we(lsu_we), .funct3(funct3),
        .addr(addr), .wdata(wdata), .lsu_busy(lsu_busy), .lsu_done(lsu_done),
        .lsu_err(lsu_err), .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  err;
        logic [31:0] rd;
        bit          chk_rd;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic expect_done(input string name, input logic [1:0] err,
                               input logic [31:0] rd, input bit chk_rd);
        exp_t e;
        e.err = err;
        e.rd = rd;
        e.chk_rd = chk_rd;
        exp_q.push_back(e);
        name_q.push_back(name);
    endtask

    // Monitor: every completion pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n && lsu_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 expected=0 err=%b", lsu_err);
            end else begin
                exp_t  e;
                string n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                check({n, "_err"}, {30'd0, lsu_err}, {30'd0, e.err});
                if (e.chk_rd) check({n, "_rdata"}, rdata, e.rd);
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d);
        lsu_req = 1'b1;
        lsu_we  = we;
        funct3  = f3;
        addr    = a;
        wdata   = d;
    endtask

    // Called just after the accepting edge; ends just after the completing edge.
    task automatic bus_phase(input string name, input logic we, input logic [31:0] a,
                             input logic [3:0] be, input logic [31:0] wd,
                             input logic [31:0] mrd, input int waits, input bit never_ack);
        int n;
        lsu_req = 1'b0;
        mem_rdata = mrd;
        n = never_ack ? int'(TO) : waits + 1;
        check({name, "_req"}, {31'd0, mem_req}, 32'd1);
        check({name, "_busy"}, {31'd0, lsu_busy}, 32'd1);
        check({name, "_we"}, {31'd0, mem_we}, {31'd0, we});
        check({name, "_addr"}, mem_addr, a);
        check({name, "_be"}, {28'd0, mem_be}, {28'd0, be});
        check({name, "_wdata"}, mem_wdata, wd);
        for (int c = 0; c < n - 1; c++) begin
            mem_ack = 1'b0;
            @(posedge clk); #1;
            check({name, "_req_hold"}, {31'd0, mem_req}, 32'd1);
            check({name, "_bus_hold"}, {mem_addr[31:4], mem_be}, {a[31:4], be});
            check({name, "_wdata_hold"}, mem_wdata, wd);
        end
        mem_ack = !never_ack;
        @(posedge clk); #1;
        mem_ack = 1'b0;
        check({name, "_req_drop"}, {31'd0, mem_req}, 32'd0);
        check({name, "_busy_drop"}, {31'd0, lsu_busy}, 32'd0);
        check({name, "_be_clear"}, {28'd0, mem_be}, 32'd0);
    endtask

    task automatic legal(input string name, input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                         input logic [31:0] wd, input logic [31:0] mrd, input int waits,
                         input bit never_ack, input logic [1:0] err, input logic [31:0] rd);
        @(posedge clk); #1;
        issue(we, f3, a, d);
        expect_done(name, err, rd, 1'b1);
        @(posedge clk); #1;
        bus_phase(name, we, {a[31:2], 2'b00}, be, wd, mrd, waits, never_ack);
    endtask

    task automatic bad(input string name, input logic we, input logic [2:0] f3,
                       input logic [31:0] a, input logic [1:0] err);
        @(posedge clk); #1;
        issue(we, f3, a, 32'h5555_AAAA);
        expect_done(name, err, 32'd0, 1'b0);
        @(posedge clk); #1;
        lsu_req = 1'b0;
        check({name, "_no_req"}, {31'd0, mem_req}, 32'd0);
        check({name, "_no_busy"}, {31'd0, lsu_busy}, 32'd0);
        check({name, "_done_now"}, {31'd0, lsu_done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        check("reset_outputs",
              {lsu_busy, lsu_done, lsu_err, mem_req, mem_we, mem_be},
              32'd0);
        check("reset_data", rdata | mem_addr | mem_wdata, 32'd0);
        #11 rst_n = 1'b1;

        legal("lw",  1'b0, 3'b010, 32'h100, 32'd0, 4'b1111, 32'd0, 32'hDEADBEEF, 0, 1'b0, 2'b00, 32'hDEADBEEF);
        legal("lb",  1'b0, 3'b000, 32'h103, 32'd0, 4'b1000, 32'd0, 32'h80FF1234, 0, 1'b0, 2'b00, 32'hFFFFFF80);
        legal("lbu", 1'b0, 3'b100, 32'h103, 32'd0, 4'b1000, 32'd0, 32'h80FF1234, 1, 1'b0, 2'b00, 32'h00000080);
        legal("lhu", 1'b0, 3'b101, 32'h102, 32'd0, 4'b1100, 32'd0, 32'h80FF1234, 0, 1'b0, 2'b00, 32'h000080FF);
        legal("lh",  1'b0, 3'b001, 32'h102, 32'd0, 4'b1100, 32'd0, 32'h80FF1234, 0, 1'b0, 2'b00, 32'hFFFF80FF);
        legal("lb0", 1'b0, 3'b000, 32'h100, 32'd0, 4'b0001, 32'd0, 32'h80FF1234, 0, 1'b0, 2'b00, 32'h00000034);
        legal("sh",  1'b1, 3'b001, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 32'hFFFFFFFF, 3, 1'b0, 2'b00, 32'd0);
        legal("sb",  1'b1, 3'b000, 32'h201, 32'h000000A5, 4'b0010, 32'hA5A5A5A5, 32'd0, 0, 1'b0, 2'b00, 32'd0);
        legal("sw",  1'b1, 3'b010, 32'h204, 32'h0BADF00D, 4'b1111, 32'h0BADF00D, 32'd0, 2, 1'b0, 2'b00, 32'd0);

        bad("lw_mis",    1'b0, 3'b010, 32'h101, 2'b01);
        bad("ld_f3_011", 1'b0, 3'b011, 32'h101, 2'b10);
        bad("st_f3_100", 1'b1, 3'b100, 32'h200, 2'b10);
        bad("lh_mis",    1'b0, 3'b001, 32'h103, 2'b01);
        bad("sw_mis",    1'b1, 3'b010, 32'h102, 2'b01);

        legal("tmo",      1'b0, 3'b010, 32'h400, 32'd0, 4'b1111, 32'd0, 32'h12345678, 0, 1'b1, 2'b11, 32'd0);
        legal("ack_last", 1'b0, 3'b010, 32'h400, 32'd0, 4'b1111, 32'd0, 32'h12345678, 3, 1'b0, 2'b00, 32'h12345678);

        // Reset in the middle of an access: everything clears at once, no completion.
        @(posedge clk); #1;
        issue(1'b0, 3'b010, 32'h500, 32'd0);
        @(posedge clk); #1;
        lsu_req = 1'b0;
        check("rst_pre_req", {31'd0, mem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {lsu_busy, lsu_done, lsu_err, mem_req, mem_we, mem_be}, 32'd0);
        check("rst_mid_data", rdata | mem_addr | mem_wdata, 32'd0);
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;

        // Back-to-back: second request presented during the done cycle of the first.
        @(posedge clk); #1;
        issue(1'b0, 3'b010, 32'h300, 32'd0);
        expect_done("b2b_lw", 2'b00, 32'h11223344, 1'b1);
        @(posedge clk); #1;
        bus_phase("b2b_lw", 1'b0, 32'h300, 4'b1111, 32'd0, 32'h11223344, 0, 1'b0);
        check("b2b_done_cycle", {31'd0, lsu_done}, 32'd1);
        issue(1'b1, 3'b010, 32'h304, 32'hCAFEF00D);
        expect_done("b2b_sw", 2'b00, 32'd0, 1'b1);
        @(posedge clk); #1;
        check("b2b_done_fell", {31'd0, lsu_done}, 32'd0);
        bus_phase("b2b_sw", 1'b1, 32'h304, 4'b1111, 32'hCAFEF00D, 32'd0, 0, 1'b0);

        repeat (4) @(posedge clk);
        #1;
        check("err_held", {30'd0, lsu_err}, 32'd0);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
